rv_dp: RTL and testbench
========================

# rv_dp

Datapath for the multicycle RISC-V core: program counter, instruction register, register file, immediate generator, ALU, and the inter-cycle registers that carry values between states. It is driven cycle-by-cycle by the control plane (`rv_ctl`). It returns `instr` and `zero` to the control plane and presents instruction and data addresses/data to memory. The memory write strobe (`memrw`) goes from the control plane straight to memory and does not pass through this block.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset

Ports:
- clk  in  1  clock, all registers rising-edge
- rst  in  1  reset, asynchronous, active-high
- pcsourse  in  1  next-PC select: 0 = PC_INC (PC+4), 1 = PC_ALU
- pcwrite  in  1  PC load enable
- pccen  in  1  PCC (current-instruction PC) load enable
- irwrite  in  1  IR load enable
- wbsel  in  2  register write-back select: 0 = WB_PC, 1 = WB_ALUOUT, 2 = WB_MDR, 3 = write zero
- regwen  in  1  register file write enable
- immsel  in  2  immediate format: 0 = IMM_L (I-type), 1 = IMM_S, 2 = IMM_B, 3 = IMM_J
- asel  in  1  ALU A operand: 0 = ALUA_REG (A register), 1 = ALUA_PCC
- bsel  in  1  ALU B operand: 0 = ALUB_REG (B register), 1 = ALUB_IMM
- alusel  in  4  ALU operation, encoded {funct3, instr[30]}
- mdrwrite  in  1  MDR load enable
- sw2_signal  in  1  store-data select: 0 = B, 1 = halfword-swapped B
- instr  out  32  IR contents
- zero  out  1  combinational: ALU result == 0
- imem_addr  out  32  PC register
- imem_rdata  in  32  instruction word at imem_addr, combinational read
- dmem_addr  out  32  ALUOut register
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  data word at dmem_addr, combinational read

## Operation
Register file:
- 32x32 registers, all cleared on rst.
- Read addresses: rs1 = IR[19:15], rs2 = IR[24:20]; write address rd = IR[11:7].
- Synchronous write when regwen = 1. Writes to x0 are discarded; reads of x0 return 0.

Inter-cycle registers:
- A and B load the rs1/rs2 read data every cycle.
- ALUOut loads the ALU result every cycle.

Immediates (all sign-extended from instr[31]):
- I-type: IR[31:20].
- S-type: {IR[31:25], IR[11:7]}.
- B-type: {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
- J-type: {IR[31], IR[19:12], IR[20], IR[30:21], 0}.

ALU (32-bit, wrap-around, no overflow flag):
- 0000 ADD, 0001 SUB, 0010 SLL, 0100 SLT (signed), 0110 SLTU, 1000 XOR, 1010 SRL, 1011 SRA, 1100 OR, 1110 AND.
- Shift amounts use operand B[4:0].
- Any other code performs ADD.

Next PC:
- PC_INC selects PC+4.
- PC_ALU selects the ALUOut register when IR[6:0] = 1100011 (branch). Otherwise it selects the combinational ALU result (JAL).

Write-back:
- WB_PC writes the current PC register, which at this point already holds PCC+4, giving the JAL link value.
- WB_ALUOUT writes the ALUOut register; WB_MDR writes MDR.

Store data:
- dmem_wdata = B when sw2_signal = 0.
- dmem_wdata = {B[15:0], B[31:16]} when sw2_signal = 1.

Register loads on the enabling edge:
- IR <= imem_rdata (irwrite).
- PCC <= PC (pccen).
- MDR <= dmem_rdata (mdrwrite).

## Timing
Reset values: PC = RESET_PC; PCC, IR, MDR, A, B, ALUOut and all registers = 0. Consequently instr = 0, imem_addr = RESET_PC, dmem_addr = 0, dmem_wdata = 0.

An asserted rst mid-instruction clears state immediately. The first edge after release performs FETCH from RESET_PC.

Per-state timing:
- FETCH: at the edge, IR <= mem[PC], PCC <= PC, PC <= PC+4.
- DECODE: A/B capture rs1/rs2; ALUOut <= PCC + immB, the branch target.
- LSW_ADDR: ALUOut <= A + imm. The following state sees dmem_addr valid.
- LW_MEM: MDR captured. LW_WB: rd <= MDR.
- SW_MEM / SW2_MEM: dmem_addr and dmem_wdata are stable for the whole cycle.
- RTYPE_ALU: ALUOut <= A op B. RTYPE_WB: rd <= ALUOut.
- BEQ_EXEC: zero is valid combinationally in-cycle; PC <= ALUOut when pcwrite = 1.
- JAL_EXEC: rd <= PC (old) and PC <= PCC + immJ on the same edge.

Simultaneous events:
- A register write and a read of the same register in the same cycle returns the old value. There is no bypass.
- Concurrent pcwrite and pccen: PCC takes the pre-edge PC.

## Test plan
- Reset with RESET_PC = 0x100, rst deasserted, FETCH control word -> imem_addr = 0x100 → 0x104; PCC = 0x100; IR = imem_rdata.
- Reset asserted mid-instruction (during LW_MEM) -> all outputs return to reset values immediately, without waiting for a clock edge.
- x1 = 7, x2 = 5; SUB x3 (alusel 0001) through RTYPE states -> x3 = 2. The same write targeting x0 -> x0 reads 0.
- Load/store sequence:
  - SW x2 to 8(x1) -> dmem_addr = 15, dmem_wdata = 5.
  - SW2 with B = 0x1234ABCD -> dmem_wdata = 0xABCD1234.
  - LW with dmem_rdata = 0xDEADBEEF -> rd = 0xDEADBEEF.
- BEQ at PCC = 0x20, offset +16:
  - Equal operands -> zero = 1, PC = 0x30.
  - Unequal operands, pcwrite = 0 -> PC stays 0x24.
- JAL at PCC = 0x40, offset −8 -> PC = 0x38, rd = 0x44.

Source files
------------

// File: rtl/rv_dp.sv
// Multicycle RISC-V datapath: PC/PCC/IR, register file, immediate generator,
// ALU and the A/B/ALUOut/MDR registers that carry values between control states.
module rv_dp #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcsourse,
  input  logic        pcwrite,
  input  logic        pccen,
  input  logic        irwrite,
  input  logic [1:0]  wbsel,
  input  logic        regwen,
  input  logic [1:0]  immsel,
  input  logic        asel,
  input  logic        bsel,
  input  logic [3:0]  alusel,
  input  logic        mdrwrite,
  input  logic        sw2_signal,
  output logic [31:0] instr,
  output logic        zero,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0] pc, pcc, ir, mdr, a_q, b_q, aluout;
  logic [31:0] rf [32];
  logic [31:0] rs1_data, rs2_data, imm, op_a, op_b, alu_res, pc_next, wb_data;
  logic [4:0]  rs1, rs2, rd;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  always_comb begin
    imm = 32'd0;
    case (immsel)
      2'd0: imm = {{20{ir[31]}}, ir[31:20]};
      2'd1: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      2'd2: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      2'd3: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

  assign op_a = asel ? pcc : a_q;
  assign op_b = bsel ? imm : b_q;

  always_comb begin
    alu_res = op_a + op_b;
    case (alusel)
      4'b0000: alu_res = op_a + op_b;
      4'b0001: alu_res = op_a - op_b;
      4'b0010: alu_res = op_a << op_b[4:0];
      4'b0100: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      4'b0110: alu_res = {31'd0, op_a < op_b};
      4'b1000: alu_res = op_a ^ op_b;
      4'b1010: alu_res = op_a >> op_b[4:0];
      4'b1011: alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      4'b1100: alu_res = op_a | op_b;
      4'b1110: alu_res = op_a & op_b;
      default: alu_res = op_a + op_b;
    endcase
  end

  assign zero = (alu_res == 32'd0);

  // Branch target was latched into ALUOut during decode; JAL uses the live ALU sum.
  always_comb begin
    pc_next = pc + 32'd4;
    if (pcsourse)
      pc_next = (ir[6:0] == OP_BRANCH) ? aluout : alu_res;
  end

  always_comb begin
    wb_data = 32'd0;
    case (wbsel)
      2'd0: wb_data = pc;
      2'd1: wb_data = aluout;
      2'd2: wb_data = mdr;
      default: wb_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      pcc    <= 32'd0;
      ir     <= 32'd0;
      mdr    <= 32'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      aluout <= 32'd0;
    end else begin
      if (pcwrite)  pc  <= pc_next;
      if (pccen)    pcc <= pc;
      if (irwrite)  ir  <= imem_rdata;
      if (mdrwrite) mdr <= dmem_rdata;
      a_q    <= rs1_data;
      b_q    <= rs2_data;
      aluout <= alu_res;
    end
  end

  // No write bypass: a same-cycle read of rd sees the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (regwen && rd != 5'd0) begin
      rf[rd] <= wb_data;
    end
  end

  assign instr      = ir;
  assign imem_addr  = pc;
  assign dmem_addr  = aluout;
  assign dmem_wdata = sw2_signal ? {b_q[15:0], b_q[31:16]} : b_q;

endmodule

// File: tb/tb_rv_dp.sv
// Directed bench for rv_dp: drives control words state-by-state and checks
// ports against hand-computed values.
module tb_rv_dp;
  logic        clk, rst;
  logic        pcsourse, pcwrite, pccen, irwrite, regwen, asel, bsel, mdrwrite, sw2_signal;
  logic [1:0]  wbsel, immsel;
  logic [3:0]  alusel;
  logic [31:0] instr, imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        zero;

  int n_chk = 0;
  int n_fail = 0;

  rv_dp #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen),
    .irwrite(irwrite), .wbsel(wbsel), .regwen(regwen), .immsel(immsel), .asel(asel),
    .bsel(bsel), .alusel(alusel), .mdrwrite(mdrwrite), .sw2_signal(sw2_signal),
    .instr(instr), .zero(zero), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic idle();
    pcsourse = 0; pcwrite = 0; pccen = 0; irwrite = 0; wbsel = 0; regwen = 0;
    immsel = 0; asel = 0; bsel = 0; alusel = 0; mdrwrite = 0; sw2_signal = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w);
    idle(); imem_rdata = w; irwrite = 1; pccen = 1; pcwrite = 1; tick();
  endtask

  task automatic decode();
    idle(); asel = 1; bsel = 1; immsel = 2; tick();
  endtask

  task automatic exec_imm(input logic [1:0] sel);
    idle(); bsel = 1; immsel = sel; tick();
  endtask

  task automatic exec_r(input logic [3:0] op);
    idle(); alusel = op; tick();
  endtask

  task automatic wb(input logic [1:0] sel);
    idle(); regwen = 1; wbsel = sel; tick();
  endtask

  task automatic lw_mem(input logic [31:0] d);
    idle(); mdrwrite = 1; dmem_rdata = d; tick();
  endtask

  // Read a register back through the store-data path (B register).
  task automatic rd_reg(input logic [4:0] r, output logic [31:0] v);
    fetch(enc_s(12'd0, r, 5'd0));
    idle(); tick();
    v = dmem_wdata;
  endtask

  // Load PC through the JAL path with x0 + imm.
  task automatic set_pc(input logic [31:0] v);
    fetch(enc_i(v[11:0], 5'd0, 3'b000, 5'd0, 7'b0010011));
    idle(); tick();
    idle(); bsel = 1; immsel = 0; pcsourse = 1; pcwrite = 1; tick();
  endtask

  logic [3:0]  sw_op  [0:10];
  logic [31:0] sw_exp [0:10];
  logic [31:0] v;

  initial begin
    sw_op[0] = 4'b0000; sw_exp[0] = 32'hDEADBEF6;
    sw_op[1] = 4'b0001; sw_exp[1] = 32'hDEADBEE8;
    sw_op[2] = 4'b0010; sw_exp[2] = 32'h56DF7780;
    sw_op[3] = 4'b0100; sw_exp[3] = 32'h00000001;
    sw_op[4] = 4'b0110; sw_exp[4] = 32'h00000000;
    sw_op[5] = 4'b1000; sw_exp[5] = 32'hDEADBEE8;
    sw_op[6] = 4'b1010; sw_exp[6] = 32'h01BD5B7D;
    sw_op[7] = 4'b1011; sw_exp[7] = 32'hFFBD5B7D;
    sw_op[8] = 4'b1100; sw_exp[8] = 32'hDEADBEEF;
    sw_op[9] = 4'b1110; sw_exp[9] = 32'h00000007;
    sw_op[10] = 4'b0011; sw_exp[10] = 32'hDEADBEF6;

    idle(); imem_rdata = 0; dmem_rdata = 0; rst = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_imem_addr", imem_addr, 32'h100);
    chk("rst_instr", instr, 32'h0);
    chk("rst_dmem_addr", dmem_addr, 32'h0);
    chk("rst_dmem_wdata", dmem_wdata, 32'h0);
    rst = 0;

    // addi x1, x0, 7
    fetch(enc_i(12'd7, 5'd0, 3'b000, 5'd1, 7'b0010011));
    chk("fetch_pc", imem_addr, 32'h104);
    chk("fetch_ir", instr, 32'h00700093);
    idle(); asel = 1; tick();
    chk("fetch_pcc", dmem_addr, 32'h100);
    exec_imm(0);
    chk("addi_aluout", dmem_addr, 32'd7);
    wb(1);
    // addi x2, x0, 5
    fetch(enc_i(12'd5, 5'd0, 3'b000, 5'd2, 7'b0010011));
    decode(); exec_imm(0); wb(1);

    // sub x3, x1, x2
    fetch(enc_r(7'b0100000, 5'd2, 5'd1, 5'd3));
    decode(); exec_r(4'b0001);
    chk("sub_aluout", dmem_addr, 32'd2);
    wb(1);
    rd_reg(5'd3, v); chk("sub_x3", v, 32'd2);
    fetch(enc_r(7'b0100000, 5'd2, 5'd1, 5'd0));
    decode(); exec_r(4'b0001); wb(1);
    rd_reg(5'd0, v); chk("x0_zero", v, 32'd0);

    // sw x2, 8(x1)
    fetch(enc_s(12'd8, 5'd2, 5'd1));
    decode(); exec_imm(1);
    chk("sw_addr", dmem_addr, 32'd15);
    chk("sw_data", dmem_wdata, 32'd5);

    // lw x4, 0(x1)
    fetch(enc_i(12'd0, 5'd1, 3'b010, 5'd4, 7'b0000011));
    decode(); exec_imm(0);
    chk("lw_addr", dmem_addr, 32'd7);
    lw_mem(32'hDEADBEEF); wb(2);
    rd_reg(5'd4, v); chk("lw_x4", v, 32'hDEADBEEF);

    // lw x5 = 0x1234ABCD, then halfword-swapped store of x5
    fetch(enc_i(12'd0, 5'd0, 3'b010, 5'd5, 7'b0000011));
    decode(); exec_imm(0); lw_mem(32'h1234ABCD); wb(2);
    fetch(enc_s(12'd0, 5'd5, 5'd0));
    decode(); exec_imm(1);
    idle(); sw2_signal = 1; #1;
    chk("sw2_data", dmem_wdata, 32'hABCD1234);
    tick();

    // ALU sweep: rs1 = x4 (0xDEADBEEF), rs2 = x1 (7)
    fetch(enc_r(7'd0, 5'd1, 5'd4, 5'd0));
    decode();
    for (int i = 0; i < 11; i++) begin
      exec_r(sw_op[i]);
      chk($sformatf("alu_%b", sw_op[i]), dmem_addr, sw_exp[i]);
    end

    // beq x2, x2, +16 at 0x20
    set_pc(32'h20);
    chk("setpc", imem_addr, 32'h20);
    fetch(enc_b(13'd16, 5'd2, 5'd2));
    decode();
    chk("beq_target", dmem_addr, 32'h30);
    idle(); alusel = 4'b0001; pcsourse = 1; #1;
    chk("beq_eq_zero", {31'd0, zero}, 32'd1);
    pcwrite = zero; tick();
    chk("beq_taken_pc", imem_addr, 32'h30);
    // beq x1, x2, +16 at 0x20 (not taken)
    set_pc(32'h20);
    fetch(enc_b(13'd16, 5'd2, 5'd1));
    decode();
    idle(); alusel = 4'b0001; pcsourse = 1; #1;
    chk("beq_ne_zero", {31'd0, zero}, 32'd0);
    pcwrite = zero; tick();
    chk("beq_nt_pc", imem_addr, 32'h24);

    // jal x6, -8 at 0x40
    set_pc(32'h40);
    fetch(enc_j(21'h1FFFF8, 5'd6));
    decode();
    idle(); asel = 1; bsel = 1; immsel = 3; pcsourse = 1; pcwrite = 1;
    regwen = 1; wbsel = 0; tick();
    chk("jal_pc", imem_addr, 32'h38);
    rd_reg(5'd6, v); chk("jal_link", v, 32'h44);

    // reset mid-LW_MEM takes effect without a clock edge
    fetch(enc_i(12'd0, 5'd1, 3'b010, 5'd7, 7'b0000011));
    decode(); exec_imm(0);
    idle(); mdrwrite = 1; dmem_rdata = 32'h55AA55AA; #2;
    rst = 1; #1;
    chk("mid_rst_imem_addr", imem_addr, 32'h100);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_dmem_addr", dmem_addr, 32'h0);
    chk("mid_rst_dmem_wdata", dmem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    fetch(enc_s(12'd0, 5'd1, 5'd0));
    chk("post_rst_fetch_pc", imem_addr, 32'h104);
    idle(); tick();
    chk("post_rst_x1", dmem_wdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
